// File: rtl/axil_cmd_pkg.sv
// Shared types for the AXI4-Lite command master: FSM state encoding and AXI response codes.
`timescale 1ns/1ps
package axil_cmd_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_AW_W = 3'd1,
        WR_B    = 3'd2,
        RD_AR   = 3'd3,
        RD_R    = 3'd4,
        RSP     = 3'd5
    } state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/axil_cmd_master_if.sv
// Bundle of the command/response port and the five AXI4-Lite channels around axil_cmd_master.
`timescale 1ns/1ps
interface axil_cmd_master_if #(
    parameter int DW = 32,
    parameter int AW = 5
);
    logic            cmd_valid;
    logic            cmd_ready;
    logic            cmd_write;
    logic [AW-1:0]   cmd_addr;
    logic [DW-1:0]   cmd_wdata;
    logic [DW/8-1:0] cmd_wstrb;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [DW-1:0]   rsp_rdata;
    logic [1:0]      rsp_resp;

    logic [AW-1:0]   awaddr;
    logic [2:0]      awprot;
    logic            awvalid;
    logic            awready;
    logic [DW-1:0]   wdata;
    logic [DW/8-1:0] wstrb;
    logic            wvalid;
    logic            wready;
    logic [1:0]      bresp;
    logic            bvalid;
    logic            bready;
    logic [AW-1:0]   araddr;
    logic [2:0]      arprot;
    logic            arvalid;
    logic            arready;
    logic [DW-1:0]   rdata;
    logic [1:0]      rresp;
    logic            rvalid;
    logic            rready;

    // The command master's view.
    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb, rsp_ready,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_resp,
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready, araddr, arprot, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    // The opposite side: command source plus AXI4-Lite peripheral.
    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_resp,
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready, araddr, arprot, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axil_cmd_master.sv
// Turns single read/write commands into AXI4-Lite transactions, one outstanding at a time.
// Every channel uses valid/ready: a transfer happens on a rising edge where both are high; a
// producer never drops valid or changes payload before that edge, and all outputs are registered.
`timescale 1ns/1ps
module axil_cmd_master
    import axil_cmd_pkg::*;
#(
    parameter int C_M_AXI_DATA_WIDTH = 32,
    parameter int C_M_AXI_ADDR_WIDTH = 5
) (
    input  logic                            M_AXI_ACLK,
    input  logic                            M_AXI_ARESETN,
    input  logic                            cmd_valid,
    output logic                            cmd_ready,
    input  logic                            cmd_write,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [C_M_AXI_DATA_WIDTH/8-1:0] cmd_wstrb,
    output logic                            rsp_valid,
    input  logic                            rsp_ready,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   rsp_rdata,
    output logic [1:0]                      rsp_resp,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
    output logic [2:0]                      M_AXI_AWPROT,
    output logic                            M_AXI_AWVALID,
    input  logic                            M_AXI_AWREADY,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
    output logic                            M_AXI_WVALID,
    input  logic                            M_AXI_WREADY,
    input  logic [1:0]                      M_AXI_BRESP,
    input  logic                            M_AXI_BVALID,
    output logic                            M_AXI_BREADY,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
    output logic [2:0]                      M_AXI_ARPROT,
    output logic                            M_AXI_ARVALID,
    input  logic                            M_AXI_ARREADY,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
    input  logic [1:0]                      M_AXI_RRESP,
    input  logic                            M_AXI_RVALID,
    output logic                            M_AXI_RREADY,
    output state_e                          dbg_state
);

    state_e state;

    assign M_AXI_AWPROT = 3'b000;
    assign M_AXI_ARPROT = 3'b000;
    assign dbg_state    = state;

    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            state         <= IDLE;
            cmd_ready     <= 1'b0;
            rsp_valid     <= 1'b0;
            rsp_rdata     <= '0;
            rsp_resp      <= '0;
            M_AXI_AWADDR  <= '0;
            M_AXI_AWVALID <= 1'b0;
            M_AXI_WDATA   <= '0;
            M_AXI_WSTRB   <= '0;
            M_AXI_WVALID  <= 1'b0;
            M_AXI_BREADY  <= 1'b0;
            M_AXI_ARADDR  <= '0;
            M_AXI_ARVALID <= 1'b0;
            M_AXI_RREADY  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    cmd_ready <= 1'b1;
                    if (cmd_valid && cmd_ready) begin
                        cmd_ready <= 1'b0;
                        if (cmd_write) begin
                            M_AXI_AWADDR  <= cmd_addr;
                            M_AXI_WDATA   <= cmd_wdata;
                            M_AXI_WSTRB   <= cmd_wstrb;
                            M_AXI_AWVALID <= 1'b1;
                            M_AXI_WVALID  <= 1'b1;
                            state         <= WR_AW_W;
                        end else begin
                            M_AXI_ARADDR  <= cmd_addr;
                            M_AXI_ARVALID <= 1'b1;
                            state         <= RD_AR;
                        end
                    end
                end
                WR_AW_W: begin
                    // AW and W complete independently; a channel already done counts as finished.
                    if (M_AXI_AWREADY) M_AXI_AWVALID <= 1'b0;
                    if (M_AXI_WREADY)  M_AXI_WVALID  <= 1'b0;
                    if ((!M_AXI_AWVALID || M_AXI_AWREADY) && (!M_AXI_WVALID || M_AXI_WREADY)) begin
                        M_AXI_BREADY <= 1'b1;
                        state        <= WR_B;
                    end
                end
                WR_B: begin
                    if (M_AXI_BVALID) begin
                        M_AXI_BREADY <= 1'b0;
                        rsp_resp     <= M_AXI_BRESP;
                        rsp_rdata    <= '0;
                        rsp_valid    <= 1'b1;
                        state        <= RSP;
                    end
                end
                RD_AR: begin
                    if (M_AXI_ARREADY) begin
                        M_AXI_ARVALID <= 1'b0;
                        M_AXI_RREADY  <= 1'b1;
                        state         <= RD_R;
                    end
                end
                RD_R: begin
                    if (M_AXI_RVALID) begin
                        M_AXI_RREADY <= 1'b0;
                        rsp_resp     <= M_AXI_RRESP;
                        rsp_rdata    <= M_AXI_RDATA;
                        rsp_valid    <= 1'b1;
                        state        <= RSP;
                    end
                end
                RSP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axil_cmd_master.sv
// Directed plus randomized checks of axil_cmd_master against a word-array model of the peripheral.
`timescale 1ns/1ps
module tb_axil_cmd_master;
    import axil_cmd_pkg::*;

    localparam int DW = 32;
    localparam int AW = 5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    axil_cmd_master_if #(.DW(DW), .AW(AW)) bus ();
    state_e dbg_state;

    axil_cmd_master #(.C_M_AXI_DATA_WIDTH(DW), .C_M_AXI_ADDR_WIDTH(AW)) dut (
        .M_AXI_ACLK(clk), .M_AXI_ARESETN(rst_n),
        .cmd_valid(bus.cmd_valid), .cmd_ready(bus.cmd_ready), .cmd_write(bus.cmd_write),
        .cmd_addr(bus.cmd_addr), .cmd_wdata(bus.cmd_wdata), .cmd_wstrb(bus.cmd_wstrb),
        .rsp_valid(bus.rsp_valid), .rsp_ready(bus.rsp_ready), .rsp_rdata(bus.rsp_rdata),
        .rsp_resp(bus.rsp_resp),
        .M_AXI_AWADDR(bus.awaddr), .M_AXI_AWPROT(bus.awprot), .M_AXI_AWVALID(bus.awvalid),
        .M_AXI_AWREADY(bus.awready), .M_AXI_WDATA(bus.wdata), .M_AXI_WSTRB(bus.wstrb),
        .M_AXI_WVALID(bus.wvalid), .M_AXI_WREADY(bus.wready), .M_AXI_BRESP(bus.bresp),
        .M_AXI_BVALID(bus.bvalid), .M_AXI_BREADY(bus.bready), .M_AXI_ARADDR(bus.araddr),
        .M_AXI_ARPROT(bus.arprot), .M_AXI_ARVALID(bus.arvalid), .M_AXI_ARREADY(bus.arready),
        .M_AXI_RDATA(bus.rdata), .M_AXI_RRESP(bus.rresp), .M_AXI_RVALID(bus.rvalid),
        .M_AXI_RREADY(bus.rready), .dbg_state(dbg_state)
    );

    int n_assert = 0;
    int n_fail   = 0;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (s[b]) r[b*8 +: 8] = d[b*8 +: 8];
        return r;
    endfunction

    // ---------------- peripheral model: 8-word register file with programmable stalls
    int          aw_delay = 0, w_delay = 0, ar_delay = 0;
    logic [1:0]  bresp_cfg = RESP_OKAY, rresp_cfg = RESP_OKAY;
    logic        pre_en = 1'b0;
    logic [2:0]  pre_idx = '0;
    logic [31:0] pre_data = '0;

    int          aw_cnt, w_cnt, ar_cnt;
    logic        aw_got, w_got;
    logic [2:0]  aw_idx;
    logic [31:0] w_hold;
    logic [3:0]  s_hold;
    logic [31:0] mem [8];

    assign bus.awready = bus.awvalid && (aw_cnt >= aw_delay);
    assign bus.wready  = bus.wvalid  && (w_cnt  >= w_delay);
    assign bus.arready = bus.arvalid && (ar_cnt >= ar_delay);

    wire         aw_hs   = bus.awvalid && bus.awready;
    wire         w_hs    = bus.wvalid && bus.wready;
    wire         ar_hs   = bus.arvalid && bus.arready;
    wire         a_done  = aw_got || aw_hs;
    wire         d_done  = w_got || w_hs;
    wire [2:0]   wr_idx  = aw_hs ? bus.awaddr[4:2] : aw_idx;
    wire [31:0]  wr_data = w_hs ? bus.wdata : w_hold;
    wire [3:0]   wr_strb = w_hs ? bus.wstrb : s_hold;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0;
            aw_got <= 1'b0; w_got <= 1'b0;
            aw_idx <= '0; w_hold <= '0; s_hold <= '0;
            bus.bvalid <= 1'b0; bus.bresp <= '0;
            bus.rvalid <= 1'b0; bus.rresp <= '0; bus.rdata <= '0;
        end else begin
            if (pre_en) mem[pre_idx] <= pre_data;
            aw_cnt <= (bus.awvalid && !bus.awready) ? aw_cnt + 1 : 0;
            w_cnt  <= (bus.wvalid && !bus.wready) ? w_cnt + 1 : 0;
            ar_cnt <= (bus.arvalid && !bus.arready) ? ar_cnt + 1 : 0;
            if (aw_hs) aw_idx <= bus.awaddr[4:2];
            if (w_hs) begin w_hold <= bus.wdata; s_hold <= bus.wstrb; end
            if (a_done && d_done) begin
                mem[wr_idx] <= merge(mem[wr_idx], wr_data, wr_strb);
                bus.bvalid  <= 1'b1;
                bus.bresp   <= bresp_cfg;
                aw_got      <= 1'b0;
                w_got       <= 1'b0;
            end else begin
                if (aw_hs) aw_got <= 1'b1;
                if (w_hs)  w_got  <= 1'b1;
            end
            if (bus.bvalid && bus.bready) bus.bvalid <= 1'b0;
            if (ar_hs) begin
                bus.rvalid <= 1'b1;
                bus.rdata  <= mem[bus.araddr[4:2]];
                bus.rresp  <= rresp_cfg;
            end else if (bus.rvalid && bus.rready) begin
                bus.rvalid <= 1'b0;
            end
        end
    end

    // ---------------- bus monitor: protocol rules and payload capture
    int          proto_err = 0, awv_cyc = 0, wv_cyc = 0;
    logic [4:0]  seen_awaddr = '0, seen_araddr = '0;
    logic [31:0] seen_wdata = '0;
    logic [3:0]  seen_wstrb = '0;
    logic        p_awv = 0, p_awr = 0, p_wv = 0, p_wr = 0, p_arv = 0, p_arr = 0;
    logic [4:0]  p_awaddr = '0, p_araddr = '0;
    logic [31:0] p_wdata = '0;
    logic [3:0]  p_wstrb = '0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (p_awv && !p_awr && (!bus.awvalid || bus.awaddr != p_awaddr)) proto_err <= proto_err + 1;
            else if (p_wv && !p_wr && (!bus.wvalid || bus.wdata != p_wdata || bus.wstrb != p_wstrb)) proto_err <= proto_err + 1;
            else if (p_arv && !p_arr && (!bus.arvalid || bus.araddr != p_araddr)) proto_err <= proto_err + 1;
            else if (bus.bready && (bus.awvalid || bus.wvalid)) proto_err <= proto_err + 1;
            else if (bus.awprot != 3'b000 || bus.arprot != 3'b000) proto_err <= proto_err + 1;
            if (bus.awvalid) awv_cyc <= awv_cyc + 1;
            if (bus.wvalid) wv_cyc <= wv_cyc + 1;
            if (aw_hs) seen_awaddr <= bus.awaddr;
            if (w_hs) begin seen_wdata <= bus.wdata; seen_wstrb <= bus.wstrb; end
            if (ar_hs) seen_araddr <= bus.araddr;
            p_awv <= bus.awvalid; p_awr <= bus.awready; p_awaddr <= bus.awaddr;
            p_wv <= bus.wvalid; p_wr <= bus.wready; p_wdata <= bus.wdata; p_wstrb <= bus.wstrb;
            p_arv <= bus.arvalid; p_arr <= bus.arready; p_araddr <= bus.araddr;
        end else begin
            p_awv <= 1'b0; p_wv <= 1'b0; p_arv <= 1'b0;
        end
    end

    // ---------------- checking helpers and driver
    logic [31:0] exp_mem [8];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run_cmd(input string tag, input bit wr, input logic [4:0] addr, input logic [31:0] d,
                           input logic [3:0] s, input int stall, input logic [31:0] exp_rd,
                           input logic [1:0] exp_rs, input int exp_lat);
        int  lat, pe0, n;
        bit  got;
        pe0 = proto_err;
        @(negedge clk);
        bus.cmd_valid = 1'b1; bus.cmd_write = wr; bus.cmd_addr = addr;
        bus.cmd_wdata = d; bus.cmd_wstrb = s;
        got = 1'b0; n = 0;
        while (!got && n < 20) begin
            if (bus.cmd_ready) got = 1'b1;
            else begin @(negedge clk); n++; end
        end
        check({tag, "_accept"}, got, 1'b1);
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        got = 1'b0; lat = 0;
        while (!got && lat < 60) begin
            @(negedge clk); lat++;
            got = bus.rsp_valid;
        end
        check({tag, "_rsp_seen"}, got, 1'b1);
        check({tag, "_latency"}, lat, exp_lat);
        check({tag, "_rdata"}, bus.rsp_rdata, exp_rd);
        check({tag, "_resp"}, bus.rsp_resp, exp_rs);
        for (int k = 0; k < stall; k++) begin
            bus.cmd_valid = 1'b1; bus.cmd_write = ~wr; bus.cmd_addr = ~addr;
            @(negedge clk);
            check({tag, "_hold_valid"}, bus.rsp_valid, 1'b1);
            check({tag, "_hold_rdata"}, bus.rsp_rdata, exp_rd);
            check({tag, "_hold_resp"}, bus.rsp_resp, exp_rs);
            check({tag, "_hold_cmd_ready"}, bus.cmd_ready, 1'b0);
        end
        bus.cmd_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
        @(negedge clk);
        check({tag, "_idle_cmd_ready"}, bus.cmd_ready, 1'b1);
        check({tag, "_rsp_dropped"}, bus.rsp_valid, 1'b0);
        if (wr) begin
            check({tag, "_awaddr"}, seen_awaddr, addr);
            check({tag, "_wdata"}, seen_wdata, d);
            check({tag, "_wstrb"}, seen_wstrb, s);
        end else begin
            check({tag, "_araddr"}, seen_araddr, addr);
        end
        check({tag, "_protocol"}, proto_err - pe0, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    // ---------------- directed steps, then random traffic
    initial begin
        logic [1:0]  rtab [3];
        logic [31:0] d;
        logic [3:0]  s;
        logic [2:0]  idx;
        int          a0, w0, n, mx;
        bit          wr;

        rtab[0] = RESP_OKAY; rtab[1] = RESP_SLVERR; rtab[2] = RESP_DECERR;
        bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_addr = '0;
        bus.cmd_wdata = '0; bus.cmd_wstrb = '0; bus.rsp_ready = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_cmd_ready", bus.cmd_ready, 1'b0);
        check("rst_rsp_valid", bus.rsp_valid, 1'b0);
        check("rst_valids", {bus.awvalid, bus.wvalid, bus.arvalid}, 3'b000);
        check("rst_readies", {bus.bready, bus.rready}, 2'b00);
        check("rst_rsp_data", {bus.rsp_rdata, bus.rsp_resp}, 34'h0);
        check("rst_state", dbg_state, IDLE);
        rst_n = 1'b1;
        #1 check("rel_cmd_ready_pre_edge", bus.cmd_ready, 1'b0);
        @(negedge clk);
        check("rel_cmd_ready_first_edge", bus.cmd_ready, 1'b1);

        for (int i = 0; i < 8; i++) begin
            exp_mem[i] = (i == 1) ? 32'h1234_5678 : $urandom;
            pre_en = 1'b1; pre_idx = 3'(i); pre_data = exp_mem[i];
            @(negedge clk);
        end
        pre_en = 1'b0;

        run_cmd("wr_reg2", 1'b1, 5'h08, 32'hDEAD_BEEF, 4'hF, 0, 32'h0, RESP_OKAY, 3);
        exp_mem[2] = 32'hDEAD_BEEF;
        check("reg2_out", mem[2], 32'hDEAD_BEEF);

        run_cmd("rd_reg1", 1'b0, 5'h04, 32'h0, 4'h0, 0, 32'h1234_5678, RESP_OKAY, 3);

        aw_delay = 3;
        a0 = awv_cyc; w0 = wv_cyc;
        run_cmd("wr_aw_delay", 1'b1, 5'h0C, 32'hA5A5_0F0F, 4'h5, 0, 32'h0, RESP_OKAY, 6);
        exp_mem[3] = merge(exp_mem[3], 32'hA5A5_0F0F, 4'h5);
        check("awvalid_cycles", awv_cyc - a0, 4);
        check("wvalid_cycles", wv_cyc - w0, 1);
        aw_delay = 0;

        run_cmd("rd_stall", 1'b0, 5'h08, 32'h0, 4'h0, 5, exp_mem[2], RESP_OKAY, 3);

        rresp_cfg = RESP_SLVERR;
        run_cmd("rd_slverr", 1'b0, 5'h10, 32'h0, 4'h0, 0, exp_mem[4], RESP_SLVERR, 3);
        rresp_cfg = RESP_OKAY;

        bresp_cfg = RESP_DECERR;
        run_cmd("wr_decerr", 1'b1, 5'h1C, 32'h0BAD_F00D, 4'h3, 1, 32'h0, RESP_DECERR, 3);
        exp_mem[7] = merge(exp_mem[7], 32'h0BAD_F00D, 4'h3);
        bresp_cfg = RESP_OKAY;

        for (int t = 0; t < 24; t++) begin
            wr  = 1'($urandom_range(0, 1));
            idx = 3'($urandom_range(0, 7));
            d   = $urandom;
            s   = 4'($urandom_range(0, 15));
            aw_delay = $urandom_range(0, 3);
            w_delay  = $urandom_range(0, 3);
            ar_delay = $urandom_range(0, 3);
            bresp_cfg = rtab[$urandom_range(0, 2)];
            rresp_cfg = rtab[$urandom_range(0, 2)];
            if (wr) begin
                mx = (aw_delay > w_delay) ? aw_delay : w_delay;
                run_cmd("rand_wr", 1'b1, {idx, 2'b00}, d, s, $urandom_range(0, 2), 32'h0, bresp_cfg, mx + 3);
                exp_mem[idx] = merge(exp_mem[idx], d, s);
            end else begin
                run_cmd("rand_rd", 1'b0, {idx, 2'b00}, 32'h0, 4'h0, $urandom_range(0, 2),
                        exp_mem[idx], rresp_cfg, ar_delay + 3);
            end
        end
        aw_delay = 10; w_delay = 10; ar_delay = 0;
        bresp_cfg = RESP_OKAY; rresp_cfg = RESP_OKAY;

        @(negedge clk);
        bus.cmd_valid = 1'b1; bus.cmd_write = 1'b1; bus.cmd_addr = 5'h14;
        bus.cmd_wdata = 32'hFFFF_FFFF; bus.cmd_wstrb = 4'hF;
        n = 0;
        while (!bus.awvalid && n < 10) begin @(negedge clk); n++; end
        check("mid_rst_awvalid_before", bus.awvalid, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_awvalid", bus.awvalid, 1'b0);
        check("mid_rst_wvalid", bus.wvalid, 1'b0);
        check("mid_rst_cmd_ready", bus.cmd_ready, 1'b0);
        check("mid_rst_state", dbg_state, IDLE);
        bus.cmd_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1 check("mid_rel_cmd_ready_pre_edge", bus.cmd_ready, 1'b0);
        @(negedge clk);
        check("mid_rel_cmd_ready", bus.cmd_ready, 1'b1);
        aw_delay = 0; w_delay = 0;

        run_cmd("rd_after_abort", 1'b0, 5'h14, 32'h0, 4'h0, 0, exp_mem[5], RESP_OKAY, 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/axil_cmd_master.md
AXIL_CMD_MASTER -- requirements
Module: axil_cmd_master

Interface
REQ-001 SHALL have parameter C_M_AXI_DATA_WIDTH, default 32, AXI data width in bits (only 32 supported).
REQ-002 SHALL have parameter C_M_AXI_ADDR_WIDTH, default 5, AXI byte-address width.
REQ-003 SHALL have port M_AXI_ACLK  in  1  sole clock; all logic rising-edge.
REQ-004 SHALL have port M_AXI_ARESETN  in  1  asynchronous active-low reset.
REQ-005 SHALL have port cmd_valid  in  1  command request.
REQ-006 SHALL have port cmd_ready  out  1  command accepted when cmd_valid and cmd_ready are both high.
REQ-007 SHALL have port cmd_write  in  1  1 = write, 0 = read.
REQ-008 SHALL have port cmd_addr  in  ADDR_WIDTH  byte address.
REQ-009 SHALL have port cmd_wdata  in  DATA_WIDTH  write data.
REQ-010 SHALL have port cmd_wstrb  in  DATA_WIDTH/8  write byte strobes.
REQ-011 SHALL have port rsp_valid  out  1  response available.
REQ-012 SHALL have port rsp_ready  in  1  response consumed.
REQ-013 SHALL have port rsp_rdata  out  DATA_WIDTH  read data; 0 for writes.
REQ-014 SHALL have port rsp_resp  out  2  captured BRESP or RRESP.
REQ-015 SHALL have AW channel M_AXI_AWADDR/AWPROT[2:0]/AWVALID out, M_AXI_AWREADY in.
REQ-016 SHALL have W channel M_AXI_WDATA/WSTRB/WVALID out, M_AXI_WREADY in.
REQ-017 SHALL have B channel M_AXI_BRESP[1:0]/BVALID in, M_AXI_BREADY out.
REQ-018 SHALL have AR channel M_AXI_ARADDR/ARPROT[2:0]/ARVALID out, M_AXI_ARREADY in.
REQ-019 SHALL have R channel M_AXI_RDATA/RRESP[1:0]/RVALID in, M_AXI_RREADY out.

Function
REQ-020 SHALL implement FSM states IDLE, WR_AW_W, WR_B, RD_AR, RD_R, RSP; one transaction outstanding at a time.
REQ-021 SHALL drive cmd_ready=1 only in IDLE; on accept, register addr/wdata/wstrb and go to WR_AW_W (write) or RD_AR (read).
REQ-022 SHALL assert AWVALID and WVALID together the cycle after accept; each drops the cycle after its own handshake, independently.
REQ-023 SHALL go WR_AW_W -> WR_B once both AW and W handshakes are done, including same-cycle completion of both.
REQ-024 SHALL assert BREADY only in WR_B; on BVALID, capture BRESP, set rsp_rdata=0, go to RSP.
REQ-025 SHALL assert ARVALID the cycle after a read accept, holding until ARREADY, then go to RD_R.
REQ-026 SHALL assert RREADY only in RD_R; on RVALID, capture RDATA/RRESP, go to RSP.
REQ-027 SHALL assert rsp_valid in RSP with rsp_rdata/rsp_resp stable until rsp_ready, then return to IDLE (cmd_ready high next cycle).
REQ-028 SHALL never deassert any VALID before its handshake; payload stays constant while VALID is high.
REQ-029 SHALL drive AWPROT=ARPROT=3'b000 and pass addresses unmodified.
REQ-030 SHALL, with zero-wait slave, give write cmd-accept to rsp_valid = 3 cycles and read = 3 cycles.
REQ-031 SHALL ignore cmd_valid outside IDLE; BVALID/RVALID outside WR_B/RD_R have no effect.

Reset
REQ-032 SHALL, on M_AXI_ARESETN low (asynchronous, mid-transaction included), force IDLE and drive all VALID/READY outputs and rsp_valid to 0, cmd_ready to 0, and data/resp outputs to 0.
REQ-033 SHALL raise cmd_ready on the first clock edge after reset release.

Structure
REQ-034 SHALL place the FSM state enum and AXI response constants (OKAY=2'b00, SLVERR=2'b10, DECERR=2'b11) in package axil_cmd_pkg.
REQ-035 SHALL be a single flat module; no sub-module.

Verification
REQ-036 SHALL verify: write addr 0x08 data 0xDEADBEEF strb 0xF to axi_regfile zero-wait -> reg2_out=0xDEADBEEF, rsp_resp=0, rsp_rdata=0.
REQ-037 SHALL verify: AWREADY delayed 3 cycles, WREADY immediate -> WVALID high 1 cycle, AWVALID high 4 cycles with stable AWADDR, BREADY only after both.
REQ-038 SHALL verify: read addr 0x04 with reg1_in=0x12345678 -> rsp_rdata=0x12345678, rsp_resp=0.
REQ-039 SHALL verify: rsp_ready low 5 cycles -> rsp held stable, cmd_ready low, concurrent cmd_valid ignored.
REQ-040 SHALL verify: slave returns RRESP=2'b10 -> rsp_resp=2'b10.
REQ-041 SHALL verify: reset asserted while AWVALID high -> AWVALID low immediately without a clock edge; cmd_ready=1 one cycle after release.
